// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multiport register file.
// Holds the clear-sequencer state encoding used by the top and the clear controller.
package regfile_pkg;

    localparam int DEFAULT_DEPTH = 32;
    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_t;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer: walks every entry index once, one per enabled cycle.
// clear_busy is high for the whole walk; requests arriving mid-walk are ignored.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     clear_req,
    output logic                     clear_busy,
    output logic [$clog2(DEPTH)-1:0] clear_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    clear_state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            clear_idx <= '0;
        end else if (enable) begin
            unique case (state)
                IDLE: begin
                    if (clear_req) begin
                        state     <= CLEAR;
                        clear_idx <= '0;
                    end
                end
                CLEAR: begin
                    if (clear_idx == LAST_IDX) begin
                        state     <= IDLE;
                        clear_idx <= '0;
                    end else begin
                        clear_idx <= clear_idx + 1'b1;
                    end
                end
            endcase
        end
    end

    assign clear_busy = (state == CLEAR);

endmodule

// File: rtl/multiport_register_file.sv
// One-write, two-read register file with registered reads and a sequenced clear.
// Define REGFILE_BYPASS_EN to forward same-edge write data to a matching read.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     write_en,
    input  logic [$clog2(DEPTH)-1:0] write_addr,
    input  logic [WIDTH-1:0]         write_data,
    input  logic                     rd_en_a,
    input  logic [$clog2(DEPTH)-1:0] read_addr_a,
    input  logic                     rd_en_b,
    input  logic [$clog2(DEPTH)-1:0] read_addr_b,
    output logic [WIDTH-1:0]         read_data_a,
    output logic [WIDTH-1:0]         read_data_b,
    output logic                     read_valid_a,
    output logic                     read_valid_b,
    input  logic                     clear_req,
    output logic                     clear_busy
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    clear_idx;
    logic             wr_legal;
    logic             rd_legal_a;
    logic             rd_legal_b;
    logic             wr_commit;
    logic [WIDTH-1:0] rd_val_a;
    logic [WIDTH-1:0] rd_val_b;

    // Out-of-range indices only exist when DEPTH is not a power of two.
    function automatic logic is_legal(input logic [AW-1:0] addr);
        return (32'(addr) < DEPTH) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    assign wr_legal   = is_legal(write_addr);
    assign rd_legal_a = is_legal(read_addr_a);
    assign rd_legal_b = is_legal(read_addr_b);
    assign wr_commit  = enable && write_en && !clear_busy && wr_legal;

    always_comb begin
        rd_val_a = '0;
        if (rd_legal_a) begin
            rd_val_a = mem[read_addr_a];
`ifdef REGFILE_BYPASS_EN
            if (wr_commit && (write_addr == read_addr_a)) begin
                rd_val_a = write_data;
            end
`endif
        end
    end

    always_comb begin
        rd_val_b = '0;
        if (rd_legal_b) begin
            rd_val_b = mem[read_addr_b];
`ifdef REGFILE_BYPASS_EN
            if (wr_commit && (write_addr == read_addr_b)) begin
                rd_val_b = write_data;
            end
`endif
        end
    end

    regfile_clear_ctrl #(
        .DEPTH(DEPTH)
    ) u_clear_ctrl (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .clear_req (clear_req),
        .clear_busy(clear_busy),
        .clear_idx (clear_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enable) begin
            if (clear_busy) begin
                mem[clear_idx] <= '0;
            end else if (wr_commit) begin
                mem[write_addr] <= write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_a  <= '0;
            read_data_b  <= '0;
            read_valid_a <= 1'b0;
            read_valid_b <= 1'b0;
        end else begin
            read_valid_a <= enable && rd_en_a;
            read_valid_b <= enable && rd_en_b;
            if (enable && rd_en_a) begin
                read_data_a <= rd_val_a;
            end
            if (enable && rd_en_b) begin
                read_data_b <= rd_val_b;
            end
        end
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file (DEPTH=32, WIDTH=32, ZERO_REG=1).
// Vector table for single-cycle behaviour, hand sequences for clear, reset and enable.
module tb_multiport_register_file;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        rd_en_a;
    logic [4:0]  read_addr_a;
    logic        rd_en_b;
    logic [4:0]  read_addr_b;
    logic [31:0] read_data_a;
    logic [31:0] read_data_b;
    logic        read_valid_a;
    logic        read_valid_b;
    logic        clear_req;
    logic        clear_busy;

    int checks;
    int failures;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] SAME_EDGE7 = 32'hA5A5_A5A5;
`else
    localparam logic [31:0] SAME_EDGE7 = 32'h0000_0011;
`endif

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ra_en;
        logic [4:0]  ra;
        logic        rb_en;
        logic [4:0]  rb;
        logic        exp_va;
        logic [31:0] exp_da;
        logic        exp_vb;
        logic [31:0] exp_db;
    } vec_t;

    vec_t vecs [10];

    multiport_register_file #(
        .DEPTH   (32),
        .WIDTH   (32),
        .ZERO_REG(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .rd_en_a     (rd_en_a),
        .read_addr_a (read_addr_a),
        .rd_en_b     (rd_en_b),
        .read_addr_b (read_addr_b),
        .read_data_a (read_data_a),
        .read_data_b (read_data_b),
        .read_valid_a(read_valid_a),
        .read_valid_b(read_valid_b),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic quiet();
        enable     = 1'b1;
        write_en   = 1'b0;
        write_addr = '0;
        write_data = '0;
        rd_en_a    = 1'b0;
        read_addr_a = '0;
        rd_en_b    = 1'b0;
        read_addr_b = '0;
        clear_req  = 1'b0;
    endtask

    task automatic fill();
        for (int i = 1; i < 32; i++) begin
            write_en   = 1'b1;
            write_addr = 5'(i);
            write_data = i * 32'h0101_0101;
            tick();
        end
        write_en = 1'b0;
    endtask

    task automatic expect_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_en_a     = 1'b1;
            read_addr_a = 5'(i);
            rd_en_b     = 1'b1;
            read_addr_b = 5'(31 - i);
            tick();
            check($sformatf("%s_a[%0d]", tag, i), read_data_a, 32'h0);
            check($sformatf("%s_b[%0d]", tag, 31 - i), read_data_b, 32'h0);
        end
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
    endtask

    initial begin
        int  n_en;
        bit  done;

        checks   = 0;
        failures = 0;

        vecs[0] = '{1, 5'd5,  32'hDEAD_BEEF, 0, 5'd0,  0, 5'd0,
                    0, 32'h0, 0, 32'h0};
        vecs[1] = '{0, 5'd0,  32'h0,         1, 5'd5,  0, 5'd0,
                    1, 32'hDEAD_BEEF, 0, 32'h0};
        vecs[2] = '{1, 5'd0,  32'h0000_1234, 0, 5'd0,  0, 5'd0,
                    0, 32'hDEAD_BEEF, 0, 32'h0};
        vecs[3] = '{0, 5'd0,  32'h0,         1, 5'd0,  1, 5'd0,
                    1, 32'h0, 1, 32'h0};
        vecs[4] = '{1, 5'd7,  32'h0000_0011, 0, 5'd0,  1, 5'd5,
                    0, 32'h0, 1, 32'hDEAD_BEEF};
        vecs[5] = '{1, 5'd7,  32'hA5A5_A5A5, 1, 5'd7,  1, 5'd7,
                    1, SAME_EDGE7, 1, SAME_EDGE7};
        vecs[6] = '{0, 5'd0,  32'h0,         1, 5'd7,  1, 5'd5,
                    1, 32'hA5A5_A5A5, 1, 32'hDEAD_BEEF};
        vecs[7] = '{0, 5'd0,  32'h0,         1, 5'd31, 1, 5'd1,
                    1, 32'h0, 1, 32'h0};
        vecs[8] = '{1, 5'd31, 32'hCAFE_F00D, 1, 5'd7,  1, 5'd7,
                    1, 32'hA5A5_A5A5, 1, 32'hA5A5_A5A5};
        vecs[9] = '{0, 5'd0,  32'h0,         1, 5'd31, 1, 5'd31,
                    1, 32'hCAFE_F00D, 1, 32'hCAFE_F00D};

        // Reset with every request asserted: reset must win.
        quiet();
        rst       = 1'b1;
        write_en  = 1'b1;
        rd_en_a   = 1'b1;
        rd_en_b   = 1'b1;
        clear_req = 1'b1;
        tick();
        tick();
        check("rst_valid_a", 32'(read_valid_a), 32'h0);
        check("rst_valid_b", 32'(read_valid_b), 32'h0);
        check("rst_data_a", read_data_a, 32'h0);
        check("rst_data_b", read_data_b, 32'h0);
        check("rst_busy", 32'(clear_busy), 32'h0);
        rst = 1'b0;
        quiet();

        for (int v = 0; v < 10; v++) begin
            write_en    = vecs[v].we;
            write_addr  = vecs[v].wa;
            write_data  = vecs[v].wd;
            rd_en_a     = vecs[v].ra_en;
            read_addr_a = vecs[v].ra;
            rd_en_b     = vecs[v].rb_en;
            read_addr_b = vecs[v].rb;
            tick();
            check($sformatf("vec%0d_valid_a", v), 32'(read_valid_a), 32'(vecs[v].exp_va));
            check($sformatf("vec%0d_data_a", v), read_data_a, vecs[v].exp_da);
            check($sformatf("vec%0d_valid_b", v), 32'(read_valid_b), 32'(vecs[v].exp_vb));
            check($sformatf("vec%0d_data_b", v), read_data_b, vecs[v].exp_db);
        end
        quiet();

        // Enable low: no write, no read accept.
        enable      = 1'b0;
        write_en    = 1'b1;
        write_addr  = 5'd5;
        write_data  = 32'h0;
        rd_en_a     = 1'b1;
        read_addr_a = 5'd5;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("dis%0d_valid_a", k), 32'(read_valid_a), 32'h0);
            check($sformatf("dis%0d_data_a", k), read_data_a, 32'hCAFE_F00D);
        end
        quiet();
        rd_en_a     = 1'b1;
        read_addr_a = 5'd5;
        tick();
        check("dis_after_valid_a", 32'(read_valid_a), 32'h1);
        check("dis_after_data_a", read_data_a, 32'hDEAD_BEEF);
        quiet();

        // Full clear with a same-edge write, a mid-run pause and held clear_req.
        fill();
        write_en   = 1'b1;
        write_addr = 5'd3;
        write_data = 32'h0000_0333;
        clear_req  = 1'b1;
        tick();
        check("clr_start_busy", 32'(clear_busy), 32'h1);
        write_addr = 5'd2;
        write_data = 32'h0000_0BAD;
        n_en = 0;
        done = 1'b0;
        for (int it = 0; it < 200; it++) begin
            enable  = !(it >= 5 && it < 8);
            rd_en_a = (it == 4);
            rd_en_b = (it == 4);
            read_addr_a = 5'd20;
            read_addr_b = 5'd1;
            tick();
            if (enable) n_en++;
            if (it == 4) begin
                check("clr_mid_data_a", read_data_a, 32'h1414_1414);
                check("clr_mid_data_b", read_data_b, 32'h0);
            end
            if (it >= 5 && it < 8) begin
                check($sformatf("clr_pause%0d_busy", it), 32'(clear_busy), 32'h1);
            end
            if (!clear_busy) begin
                done = 1'b1;
                break;
            end
        end
        check("clr_finished", 32'(done), 32'h1);
        check("clr_enabled_cycles", 32'(n_en), 32'd32);
        quiet();
        tick();
        check("clr_no_restart", 32'(clear_busy), 32'h0);
        expect_all_zero("clr");
        quiet();

        // Reset in the middle of a clear.
        fill();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            rd_en_a     = (k == 9);
            read_addr_a = 5'd25;
            tick();
        end
        check("rstclr_pre_valid_a", 32'(read_valid_a), 32'h1);
        check("rstclr_pre_data_a", read_data_a, 32'h1919_1919);
        check("rstclr_pre_busy", 32'(clear_busy), 32'h1);
        rst        = 1'b1;
        rd_en_b    = 1'b1;
        read_addr_b = 5'd30;
        write_en   = 1'b1;
        write_addr = 5'd4;
        write_data = 32'h0000_0444;
        tick();
        check("rstclr_busy", 32'(clear_busy), 32'h0);
        check("rstclr_valid_a", 32'(read_valid_a), 32'h0);
        check("rstclr_valid_b", 32'(read_valid_b), 32'h0);
        check("rstclr_data_a", read_data_a, 32'h0);
        check("rstclr_data_b", read_data_b, 32'h0);
        rst = 1'b0;
        quiet();
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("rstclr_idle%0d_valid_a", k), 32'(read_valid_a), 32'h0);
            check($sformatf("rstclr_idle%0d_valid_b", k), 32'(read_valid_b), 32'h0);
            check($sformatf("rstclr_idle%0d_busy", k), 32'(clear_busy), 32'h0);
        end
        expect_all_zero("rstclr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 Parameter DEPTH, default 32, number of entries; SHALL be at least 2.
REQ-002 Parameter WIDTH, default 32, bits per entry.
REQ-003 Parameter ZERO_REG, default 1; when 1, entry 0 reads as zero and ignores writes.
REQ-004 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port enable  in  1  global enable; when low, no write, no read accept, clear sequence pauses.
REQ-007 Port write_en  in  1  write request.
REQ-008 Port write_addr  in  $clog2(DEPTH)  write index.
REQ-009 Port write_data  in  WIDTH  write value.
REQ-010 Port rd_en_a / rd_en_b  in  1  read request, ports A and B.
REQ-011 Port read_addr_a / read_addr_b  in  $clog2(DEPTH)  read index, ports A and B.
REQ-012 Port read_data_a / read_data_b  out  WIDTH  registered read result.
REQ-013 Port read_valid_a / read_valid_b  out  1  high for one cycle when matching read_data is new.
REQ-014 Port clear_req  in  1  request to zero every entry.
REQ-015 Port clear_busy  out  1  high while the clear sequence runs.

Function
REQ-016 Write commits at a clock edge iff enable && write_en && !clear_busy; entry write_addr takes write_data.
REQ-017 Writes to index >= DEPTH, or to index 0 with ZERO_REG=1, SHALL be dropped without side effect.
REQ-018 Read latency is one cycle: a read accepted (enable && rd_en_x) at edge N drives read_data_x and read_valid_x=1 after edge N.
REQ-019 read_valid_x SHALL be 0 in any cycle not following an accepted read; read_data_x holds its last value.
REQ-020 Reads of index >= DEPTH, or of index 0 with ZERO_REG=1, SHALL return all zeros with read_valid_x=1.
REQ-021 Ports A and B are independent; both may read the same index in the same cycle with identical results.
REQ-022 Clear FSM states: IDLE, CLEAR; IDLE -> CLEAR on an edge with enable && clear_req.
REQ-023 In CLEAR, a counter starting at 0 zeroes one entry per enabled edge; after entry DEPTH-1 the FSM returns to IDLE, so a clear takes exactly DEPTH enabled cycles.
REQ-024 clear_busy SHALL equal (state == CLEAR); clear_req while in CLEAR SHALL be ignored.
REQ-025 Reads during CLEAR are accepted and return current contents (cleared entries read 0).
REQ-026 A write and clear_req on the same IDLE edge: the write commits, then the clear sequence zeroes it.

Reset
REQ-027 On an edge with rst=1, all entries, read_data_a/b and clear counter SHALL become 0, read_valid_a/b and clear_busy 0, FSM IDLE.
REQ-028 rst SHALL take priority over enable, writes, reads and clear; reset during CLEAR aborts the sequence.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined: a read and a committing write to the same legal index on the same edge SHALL return write_data.
REQ-030 Macro REGFILE_BYPASS_EN undefined: that read SHALL return the value held before the write; the new value is visible from the next read.

Structure
REQ-031 Package regfile_pkg SHALL hold the clear-FSM state enum (IDLE, CLEAR) and default DEPTH/WIDTH constants.
REQ-032 Clear FSM and counter SHALL be a sub-module regfile_clear_ctrl, outputting clear_busy and the clear index.

Verification
REQ-033 Reset, then write 0xDEADBEEF to entry 5, read A at 5 next cycle -> read_data_a=0xDEADBEEF, read_valid_a=1 one cycle after the read request.
REQ-034 ZERO_REG=1: write 0x1234 to entry 0, read A and B at 0 -> both 0x00000000.
REQ-035 Same-edge write 0xA5A5A5A5 to entry 7 and read A at 7 (old value 0x11) -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x11 without.
REQ-036 Fill entries 1..31, pulse clear_req -> clear_busy high exactly 32 cycles; writes during busy are dropped; all reads afterwards 0.
REQ-037 Assert rst at clear cycle 10 -> clear_busy 0 next cycle, all entries 0, no valid pulses.
REQ-038 Hold enable=0 with write_en=1 and rd_en_a=1 for 3 cycles -> no entry changes, read_valid_a stays 0, clear counter frozen.
